spi2adc: RTL and testbench

SPI2ADC -- requirements
Module: spi2adc

---
 rtl/spi2adc_pkg.sv | 31 +++
 rtl/spi2adc_sck_gen.sv | 40 ++++
 rtl/spi2adc.sv | 142 ++++++++++++++
 tb/tb_spi2adc.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/spi2adc_pkg.sv
// Shared types and constants for the SPI ADC front end (MCP3002-style 16-clock frame).
package spi2adc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int unsigned NUM_SCK        = 16;
  localparam int unsigned DATA_FIRST_SCK = 6;
  localparam int unsigned DATA_LAST_SCK  = 15;

  localparam logic CMD_START = 1'b1;
  localparam logic CMD_SGL   = 1'b1;
  localparam logic CMD_MSBF  = 1'b1;

  // Command bit driven during SCK period idx (1-based); zeros after the header.
  function automatic logic cmd_bit(input logic [4:0] idx, input logic ch);
    logic b;
    case (idx)
      5'd1:    b = CMD_START;
      5'd2:    b = CMD_SGL;
      5'd3:    b = ch;
      5'd4:    b = CMD_MSBF;
      default: b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/spi2adc_sck_gen.sv
// Half-period counter: emits single-cycle rise/fall enables for an SCK that
// starts in its low phase whenever run goes high.
module sck_gen #(
  parameter int CLK_DIV = 25,
  parameter int CW      = 5
) (
  input  logic          sysclk,
  input  logic          rst_n,
  input  logic          run,
  output logic          sck_rise,
  output logic          sck_fall,
  output logic [CW-1:0] cnt
);

  logic [CW-1:0] cnt_r;
  logic          phase_r;
  logic          tc_s;

  assign tc_s     = run && (cnt_r == CW'(CLK_DIV - 1));
  assign sck_rise = tc_s && !phase_r;
  assign sck_fall = tc_s && phase_r;
  assign cnt      = cnt_r;

  // Half-period counter with terminal reload; phase tracks low/high half.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r   <= '0;
      phase_r <= 1'b0;
    end else if (!run) begin
      cnt_r   <= '0;
      phase_r <= 1'b0;
    end else if (cnt_r == CW'(CLK_DIV - 1)) begin
      cnt_r   <= '0;
      phase_r <= ~phase_r;
    end else begin
      cnt_r   <= cnt_r + CW'(1);
    end
  end

endmodule

// File: rtl/spi2adc.sv
// SPI master for a 10-bit ADC: one 16-SCK frame per accepted start, result
// presented on data_out with a one-cycle data_valid strobe.
module spi2adc
  import spi2adc_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       channel,
  output logic       adc_cs,
  output logic       adc_sck,
  output logic       adc_din,
  input  logic       adc_dout,
  output logic [9:0] data_out,
  output logic       data_valid,
  output logic       busy
);

  localparam int CW = $clog2(CLK_DIV);

  state_t        state_r;
  logic          ready_r;
  logic          chan_r;
  logic [4:0]    bit_cnt_r;
  logic [9:0]    shift_r;
  logic          cs_r;
  logic          sck_r;
  logic          din_r;
  logic [9:0]    data_r;
  logic          valid_r;
  logic          busy_r;

  logic          run_s;
  logic          in_window_s;
  logic          sck_rise_s;
  logic          sck_fall_s;
  logic [CW-1:0] hcnt_s;

  sck_gen #(
    .CLK_DIV (CLK_DIV),
    .CW      (CW)
  ) u_sck_gen (
    .sysclk   (sysclk),
    .rst_n    (rst_n),
    .run      (run_s),
    .sck_rise (sck_rise_s),
    .sck_fall (sck_fall_s),
    .cnt      (hcnt_s)
  );

  // Counter runs through the frame (after the CS setup cycle) and the CS-high gap.
  always_comb begin
    run_s = 1'b0;
    case (state_r)
      XFER:    run_s = (bit_cnt_r != 5'd0);
      GAP:     run_s = 1'b1;
      default: run_s = 1'b0;
    endcase
  end

  assign in_window_s = (bit_cnt_r >= 5'(DATA_FIRST_SCK)) && (bit_cnt_r <= 5'(DATA_LAST_SCK));

  assign adc_cs     = cs_r;
  assign adc_sck    = sck_r;
  assign adc_din    = din_r;
  assign data_out   = data_r;
  assign data_valid = valid_r;
  assign busy       = busy_r;

  // Frame sequencer; bit_cnt_r==0 in XFER is the one-cycle CS-to-SCK setup.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      ready_r   <= 1'b0;
      chan_r    <= 1'b0;
      bit_cnt_r <= 5'd0;
      shift_r   <= 10'd0;
      cs_r      <= 1'b1;
      sck_r     <= 1'b0;
      din_r     <= 1'b0;
      data_r    <= 10'd0;
      valid_r   <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      ready_r <= 1'b1;
      valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start && ready_r) begin
            state_r   <= XFER;
            busy_r    <= 1'b1;
            cs_r      <= 1'b0;
            chan_r    <= channel;
            bit_cnt_r <= 5'd0;
          end
        end
        XFER: begin
          if (bit_cnt_r == 5'd0) begin
            bit_cnt_r <= 5'd1;
            din_r     <= cmd_bit(5'd1, chan_r);
          end else if (sck_rise_s) begin
            sck_r <= 1'b1;
            if (in_window_s) begin
              shift_r <= {shift_r[8:0], adc_dout};
            end
          end else if (sck_fall_s) begin
            sck_r <= 1'b0;
            if (bit_cnt_r == 5'(NUM_SCK)) begin
              state_r   <= GAP;
              cs_r      <= 1'b1;
              din_r     <= 1'b0;
              data_r    <= shift_r;
              valid_r   <= 1'b1;
              bit_cnt_r <= 5'd0;
            end else begin
              bit_cnt_r <= bit_cnt_r + 5'd1;
              din_r     <= cmd_bit(bit_cnt_r + 5'd1, chan_r);
            end
          end
        end
        GAP: begin
          // The IDLE cycle that follows completes the CLK_DIV-cycle CS-high time.
          if (hcnt_s == CW'(CLK_DIV - 2)) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r   <= IDLE;
          busy_r    <= 1'b0;
          cs_r      <= 1'b1;
          sck_r     <= 1'b0;
          din_r     <= 1'b0;
          bit_cnt_r <= 5'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi2adc.sv
// Self-checking bench for spi2adc with CLK_DIV=2 and a behavioural ADC model.
module tb_spi2adc;

  localparam int CD = 2;

  logic       sysclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       channel = 1'b0;
  logic       adc_dout = 1'b0;
  logic       adc_cs, adc_sck, adc_din, data_valid, busy;
  logic [9:0] data_out;

  always #5 sysclk = ~sysclk;

  spi2adc #(.CLK_DIV(CD)) dut (
    .sysclk     (sysclk),
    .rst_n      (rst_n),
    .start      (start),
    .channel    (channel),
    .adc_cs     (adc_cs),
    .adc_sck    (adc_sck),
    .adc_din    (adc_din),
    .adc_dout   (adc_dout),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy)
  );

  int         ncmp = 0;
  int         nfail = 0;
  int         ncyc = 0;
  int         vq[$];
  logic       din_q[$];
  logic [9:0] adc_val = 10'd0;
  logic       null_bit = 1'b0;
  int         rises = 0;
  int         cs_hi_len = 0;
  int         min_gap = 999;
  logic       saw_low = 1'b0;

  typedef struct {
    logic       ch;
    logic [9:0] val;
    logic       nb;
  } vec_t;
  vec_t vecs[10];

  // ADC reference: bit for SCK k is the sample MSB-first on SCK 6..15, null on 5, junk elsewhere.
  function automatic logic model_bit(input int k);
    if (k >= 6 && k <= 15) return adc_val[15-k];
    if (k == 5) return null_bit;
    return 1'($urandom_range(0, 1));
  endfunction

  always @(negedge adc_cs) begin
    rises    <= 0;
    adc_dout <= model_bit(1);
  end
  always @(posedge adc_sck) begin
    rises <= rises + 1;
    din_q.push_back(adc_din);
  end
  always @(negedge adc_sck) begin
    if (!adc_cs) adc_dout <= model_bit(rises + 1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge sysclk);
    ncyc++;
    if (data_valid) vq.push_back(ncyc);
    if (adc_cs) cs_hi_len++;
    else begin
      if (saw_low && cs_hi_len > 0 && cs_hi_len < min_gap) min_gap = cs_hi_len;
      saw_low   = 1'b1;
      cs_hi_len = 0;
    end
  endtask

  task automatic run_conv(input logic ch, input logic [9:0] val, input logic nb,
                          input int p1, input int p2);
    int          e0;
    int          t;
    logic [15:0] din_act;
    logic [15:0] din_exp;
    adc_val = val;
    null_bit = nb;
    din_q.delete();
    vq.delete();
    channel = ch;
    start = 1'b1;
    e0 = ncyc + 1;
    step();
    start = 1'b0;
    channel = ~ch;
    chk("busy_after_start", busy, 1);
    t = 0;
    while (vq.size() == 0 && t < 200) begin
      start = ((p1 > 0) && (ncyc - e0 == p1 - 1)) || ((p2 > 0) && (ncyc - e0 == p2 - 1));
      step();
      t++;
    end
    start = 1'b0;
    chk("valid_seen", vq.size(), 1);
    if (vq.size() > 0) chk("latency", vq[0] - e0, 32 * CD + 1);
    chk("data_out", data_out, val);
    step();
    chk("valid_one_cycle", data_valid, 0);
    chk("din_count", din_q.size(), 16);
    din_exp = 16'b0;
    din_exp[15] = 1'b1;
    din_exp[14] = 1'b1;
    din_exp[13] = ch;
    din_exp[12] = 1'b1;
    din_act = 16'b0;
    for (int i = 0; i < 16 && i < din_q.size(); i++) din_act[15-i] = din_q[i];
    chk("din_bits", din_act, din_exp);
    repeat (12) step();
    chk("single_valid", vq.size(), 1);
    chk("data_hold", data_out, val);
  endtask

  initial begin
    int e0;
    int per;
    int exp_v[$];

    // Reset state
    repeat (2) step();
    chk("rst_cs", adc_cs, 1);
    chk("rst_sck", adc_sck, 0);
    chk("rst_din", adc_din, 0);
    chk("rst_data", data_out, 0);
    chk("rst_valid", data_valid, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (3) step();

    vecs[0] = '{ch: 1'b0, val: 10'h2A5, nb: 1'b0};
    vecs[1] = '{ch: 1'b1, val: 10'h3FF, nb: 1'b0};
    vecs[2] = '{ch: 1'b0, val: 10'h001, nb: 1'b1};
    vecs[3] = '{ch: 1'b1, val: 10'h200, nb: 1'b1};
    vecs[4] = '{ch: 1'b0, val: 10'h000, nb: 1'b1};
    for (int i = 5; i < 10; i++) begin
      vecs[i].ch  = 1'($urandom_range(0, 1));
      vecs[i].val = 10'($urandom_range(0, 1023));
      vecs[i].nb  = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < 10; i++) run_conv(vecs[i].ch, vecs[i].val, vecs[i].nb, 0, 0);

    // Start re-pulsed mid-frame is ignored
    run_conv(1'b0, 10'h2A5, 1'b0, 10, 64);

    // Start held high: back-to-back frames
    adc_val = 10'h155;
    null_bit = 1'b0;
    vq.delete();
    min_gap = 999;
    saw_low = 1'b0;
    cs_hi_len = 0;
    per = 33 * CD + 1;
    channel = 1'b1;
    start = 1'b1;
    e0 = ncyc + 1;
    repeat (300) step();
    start = 1'b0;
    repeat (150) step();
    for (int k = 0; k * per < 300; k++) exp_v.push_back(e0 + k * per + 32 * CD + 1);
    chk("burst_count", vq.size(), exp_v.size());
    for (int k = 0; k < exp_v.size() && k < vq.size(); k++) chk("burst_time", vq[k], exp_v[k]);
    chk("cs_gap_min", (min_gap >= CD) && (min_gap < 999), 1);
    chk("burst_data", data_out, 10'h155);

    // Asynchronous reset mid-frame
    adc_val = 10'h3C3;
    vq.delete();
    channel = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (29) step();
    #2 rst_n = 1'b0;
    #1;
    chk("abort_cs", adc_cs, 1);
    chk("abort_sck", adc_sck, 0);
    chk("abort_busy", busy, 0);
    chk("abort_data", data_out, 0);
    repeat (2) step();
    chk("abort_no_valid", vq.size(), 0);
    start = 1'b1;
    rst_n = 1'b1;
    step();
    chk("ready_first_edge", busy, 0);
    step();
    chk("ready_second_edge", busy, 1);
    start = 1'b0;
    chk("data_after_reset", data_out, 0);
    repeat (80) step();
    chk("post_reset_valid", vq.size(), 1);
    chk("post_reset_data", data_out, 10'h3C3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
